completion_write_arbiter: RTL and testbench

Shares one AXI4 write master (AW/W/B) between NUM_REQ completion-write requesters, for example several job-completion engines writing 128-byte return records to host memory. Each requester offers a single-beat write (AW+W together). The block grants requesters round-robin, registers the payload, and drives it onto the master. It routes each B response back to its requester by AXI ID and caps in-flight writes at MAX_OUTSTANDING.

---
 rtl/completion_write_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_completion_write_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/completion_write_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI4 write master among NUM_REQ requesters; B routed back by ID.
// Latency: grant at N, master AW/W valid at N+1, IDLE again at N+2 with ready slaves; B to s_bvalid is 1 cycle.
// Backpressure: master valids hold until their own handshake; no grant in XFER or with MAX_OUTSTANDING in flight.
module completion_write_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int REQ_IDX_WIDTH   = 2,
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 1024,
    parameter int AWUSER_WIDTH    = 9,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,

    input  logic [NUM_REQ-1:0]              s_awvalid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [NUM_REQ*AWUSER_WIDTH-1:0] s_awuser,
    input  logic [NUM_REQ-1:0]              s_wvalid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_wdata,
    output logic [NUM_REQ-1:0]              s_awready,
    output logic [NUM_REQ-1:0]              s_wready,
    output logic [NUM_REQ-1:0]              s_bvalid,
    output logic [1:0]                      s_bresp,

    output logic [ID_WIDTH-1:0]             m_axi_awid,
    output logic [ADDR_WIDTH-1:0]           m_axi_awaddr,
    output logic [AWUSER_WIDTH-1:0]         m_axi_awuser,
    output logic [7:0]                      m_axi_awlen,
    output logic [2:0]                      m_axi_awsize,
    output logic [1:0]                      m_axi_awburst,
    output logic [3:0]                      m_axi_awcache,
    output logic                            m_axi_awlock,
    output logic [2:0]                      m_axi_awprot,
    output logic [3:0]                      m_axi_awqos,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,

    output logic [DATA_WIDTH-1:0]           m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]         m_axi_wstrb,
    output logic                            m_axi_wlast,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,

    input  logic [ID_WIDTH-1:0]             m_axi_bid,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,

    output logic [7:0]                      outstanding_o
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_OUTSTANDING);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic [REQ_IDX_WIDTH-1:0]   r_rr_ptr;
    logic [7:0]                 r_outstanding;
    logic                       r_awvalid;
    logic                       r_wvalid;
    logic                       r_aw_done;
    logic                       r_w_done;
    logic [ID_WIDTH-1:0]        r_awid;
    logic [ADDR_WIDTH-1:0]      r_awaddr;
    logic [AWUSER_WIDTH-1:0]    r_awuser;
    logic [DATA_WIDTH-1:0]      r_wdata;
    logic [NUM_REQ-1:0]         r_s_bvalid;
    logic [1:0]                 r_s_bresp;

    logic [NUM_REQ-1:0]         w_elig;
    logic [REQ_IDX_WIDTH-1:0]   w_scan_idx [NUM_REQ];
    logic                       w_found;
    logic [REQ_IDX_WIDTH-1:0]   w_gnt_idx;
    logic [REQ_IDX_WIDTH-1:0]   w_rr_nxt;
    logic                       w_grant;
    logic [NUM_REQ-1:0]         w_gnt_oh;
    logic                       w_aw_hs;
    logic                       w_w_hs;
    logic                       w_xfer_fin;

    assign w_elig = s_awvalid & s_wvalid;

    // Search order rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan_idx[k] = REQ_IDX_WIDTH'((32'(r_rr_ptr) + 32'(k)) % 32'(NUM_REQ));
        end
    end

    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_elig[w_scan_idx[k]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_scan_idx[k];
            end
        end
    end

    // Held off during reset so the accept outputs read 0 while rst_n is low.
    assign w_grant  = rst_n && (r_state == ST_IDLE) && w_found && (r_outstanding < MAX_CNT);
    assign w_gnt_oh = w_grant ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    assign w_rr_nxt = (w_gnt_idx == REQ_IDX_WIDTH'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    assign w_aw_hs    = r_awvalid & m_axi_awready;
    assign w_w_hs     = r_wvalid & m_axi_wready;
    assign w_xfer_fin = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_grant)    w_state_nxt = ST_XFER;
            ST_XFER: if (w_xfer_fin) w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awid    <= '0;
        end else if (w_grant) begin
            r_rr_ptr  <= w_rr_nxt;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awid    <= ID_WIDTH'(w_gnt_idx);
        end else begin
            if (w_aw_hs) begin
                r_awvalid <= 1'b0;
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_wvalid <= 1'b0;
                r_w_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_awaddr <= s_awaddr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            r_awuser <= s_awuser[w_gnt_idx*AWUSER_WIDTH +: AWUSER_WIDTH];
            r_wdata  <= s_wdata[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A grant and a B in the same cycle cancel; a B with nothing in flight leaves the count at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else if (w_grant && !m_axi_bvalid) begin
            r_outstanding <= r_outstanding + 8'd1;
        end else if (!w_grant && m_axi_bvalid && (r_outstanding != 8'd0)) begin
            r_outstanding <= r_outstanding - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_bvalid <= '0;
            r_s_bresp  <= 2'b00;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_s_bvalid[i] <= m_axi_bvalid && (m_axi_bid == ID_WIDTH'(i));
            end
            if (m_axi_bvalid) begin
                r_s_bresp <= m_axi_bresp;
            end
        end
    end

    assign s_awready     = w_gnt_oh;
    assign s_wready      = w_gnt_oh;
    assign s_bvalid      = r_s_bvalid;
    assign s_bresp       = r_s_bresp;

    assign m_axi_awid    = r_awid;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awuser  = r_awuser;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'd7;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awcache = 4'd3;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_awqos   = 4'd0;
    assign m_axi_awvalid = r_awvalid;

    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = r_wvalid;
    assign m_axi_wvalid  = r_wvalid;

    assign m_axi_bready  = 1'b1;
    assign outstanding_o = r_outstanding;

endmodule

// File: tb/tb_completion_write_arbiter.sv
// Directed bench for completion_write_arbiter: hand-computed expectations checked with immediate assertions.
module tb_completion_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int UW = 9;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      s_awvalid, s_wvalid, s_awready, s_wready, s_bvalid;
    logic [N*AW-1:0]   s_awaddr;
    logic [N*UW-1:0]   s_awuser;
    logic [N*DW-1:0]   s_wdata;
    logic [1:0]        s_bresp;
    logic [IW-1:0]     m_axi_awid, m_axi_bid;
    logic [AW-1:0]     m_axi_awaddr;
    logic [UW-1:0]     m_axi_awuser;
    logic [7:0]        m_axi_awlen;
    logic [2:0]        m_axi_awsize, m_axi_awprot;
    logic [1:0]        m_axi_awburst, m_axi_bresp;
    logic [3:0]        m_axi_awcache, m_axi_awqos;
    logic              m_axi_awlock, m_axi_awvalid, m_axi_awready;
    logic [DW-1:0]     m_axi_wdata;
    logic [DW/8-1:0]   m_axi_wstrb;
    logic              m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic              m_axi_bvalid, m_axi_bready;
    logic [7:0]        outstanding_o;

    int n_cmp = 0;
    int n_err = 0;

    completion_write_arbiter #(
        .NUM_REQ(N), .REQ_IDX_WIDTH(2), .ID_WIDTH(IW), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .AWUSER_WIDTH(UW), .MAX_OUTSTANDING(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awuser(s_awuser),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata),
        .s_awready(s_awready), .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bresp(s_bresp),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awuser(m_axi_awuser),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awcache(m_axi_awcache), .m_axi_awlock(m_axi_awlock), .m_axi_awprot(m_axi_awprot),
        .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [UW-1:0] u, input logic [DW-1:0] d);
        s_awaddr[i*AW +: AW] = a;
        s_awuser[i*UW +: UW] = u;
        s_wdata[i*DW +: DW]  = d;
    endtask

    function automatic logic [AW-1:0] rr_addr(input int i);
        return 64'h2000_0000 + 64'(i) * 64'h80;
    endfunction

    initial begin
        rst_n = 1'b0;
        s_awvalid = '0; s_wvalid = '0; s_awaddr = '0; s_awuser = '0; s_wdata = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bid = '0; m_axi_bresp = 2'b00;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("rst_awready", 64'(s_awready), 64'd0);
        chk("rst_bvalid", 64'(s_bvalid), 64'd0);
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("bready_const", 64'(m_axi_bready), 64'd1);
        rst_n = 1'b1;

        // Single request from requester 2
        set_req(2, 64'h1000_0000, 9'h05, 64'hDEAD_BEEF_0123_4567);
        s_awvalid = 4'b0100; s_wvalid = 4'b0100;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        #1;
        chk("t1_grant_aw", 64'(s_awready), 64'h4);
        chk("t1_grant_w", 64'(s_wready), 64'h4);
        tick();
        s_awvalid = '0; s_wvalid = '0;
        #1;
        chk("t1_awvalid", 64'(m_axi_awvalid), 64'd1);
        chk("t1_wvalid", 64'(m_axi_wvalid), 64'd1);
        chk("t1_wlast", 64'(m_axi_wlast), 64'd1);
        chk("t1_awid", 64'(m_axi_awid), 64'd2);
        chk("t1_awaddr", m_axi_awaddr, 64'h1000_0000);
        chk("t1_awuser", 64'(m_axi_awuser), 64'h05);
        chk("t1_wdata", m_axi_wdata, 64'hDEAD_BEEF_0123_4567);
        chk("t1_wstrb", 64'(m_axi_wstrb), 64'hFF);
        chk("t1_awsize", 64'(m_axi_awsize), 64'd7);
        chk("t1_awburst", 64'(m_axi_awburst), 64'd1);
        chk("t1_awcache", 64'(m_axi_awcache), 64'd3);
        chk("t1_awlen", 64'(m_axi_awlen), 64'd0);
        chk("t1_outstanding", 64'(outstanding_o), 64'd1);
        tick();
        chk("t1_idle_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("t1_idle_wvalid", 64'(m_axi_wvalid), 64'd0);
        m_axi_bvalid = 1'b1; m_axi_bid = 4'd2; m_axi_bresp = 2'b00;
        #1;
        chk("t1_bvalid_not_yet", 64'(s_bvalid), 64'd0);
        tick();
        m_axi_bvalid = 1'b0;
        #1;
        chk("t1_bvalid", 64'(s_bvalid), 64'h4);
        chk("t1_bresp", 64'(s_bresp), 64'd0);
        chk("t1_outstanding_dec", 64'(outstanding_o), 64'd0);
        tick();
        chk("t1_bvalid_pulse", 64'(s_bvalid), 64'd0);

        // Round-robin from a fresh reset, all four requesting
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, rr_addr(i), UW'(i), 64'(i) * 64'h1111);
        s_awvalid = 4'hF; s_wvalid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant", 64'(s_awready), 64'(4'b0001 << (k % N)));
            tick();
            chk("rr_awid", 64'(m_axi_awid), 64'(k % N));
            chk("rr_awaddr", m_axi_awaddr, rr_addr(k % N));
            chk("rr_no_grant_xfer", 64'(s_awready), 64'd0);
            tick();
        end
        s_awvalid = '0; s_wvalid = '0;
        chk("rr_outstanding", 64'(outstanding_o), 64'd5);

        // B routing: SLVERR pass-through, out-of-range bid, back-to-back responses
        m_axi_bvalid = 1'b1; m_axi_bid = 4'd1; m_axi_bresp = 2'b10;
        tick();
        m_axi_bid = 4'd5; m_axi_bresp = 2'b00;
        #1;
        chk("b_route1", 64'(s_bvalid), 64'h2);
        chk("b_slverr", 64'(s_bresp), 64'h2);
        chk("b_out4", 64'(outstanding_o), 64'd4);
        tick();
        m_axi_bid = 4'd0;
        #1;
        chk("b_bad_id", 64'(s_bvalid), 64'd0);
        chk("b_out3", 64'(outstanding_o), 64'd3);
        tick();
        tick();
        tick();
        m_axi_bvalid = 1'b0;
        #1;
        chk("b_route0", 64'(s_bvalid), 64'h1);
        chk("b_out0", 64'(outstanding_o), 64'd0);

        // Split handshake: AW stalled three cycles, W accepted immediately
        set_req(3, 64'h3333_0000, 9'h1A3, 64'h3);
        s_awvalid = 4'b1000; s_wvalid = 4'b1000;
        m_axi_awready = 1'b0; m_axi_wready = 1'b1;
        #1;
        chk("sp_grant3", 64'(s_awready), 64'h8);
        tick();
        s_awvalid = 4'b0010; s_wvalid = 4'b0010;
        #1;
        chk("sp_awvalid1", 64'(m_axi_awvalid), 64'd1);
        chk("sp_wvalid1", 64'(m_axi_wvalid), 64'd1);
        chk("sp_awid", 64'(m_axi_awid), 64'd3);
        chk("sp_nogrant1", 64'(s_awready), 64'd0);
        tick();
        chk("sp_wvalid_drop", 64'(m_axi_wvalid), 64'd0);
        chk("sp_awvalid2", 64'(m_axi_awvalid), 64'd1);
        chk("sp_awaddr2", m_axi_awaddr, 64'h3333_0000);
        chk("sp_nogrant2", 64'(s_awready), 64'd0);
        tick();
        chk("sp_awvalid3", 64'(m_axi_awvalid), 64'd1);
        chk("sp_awaddr3", m_axi_awaddr, 64'h3333_0000);
        chk("sp_nogrant3", 64'(s_awready), 64'd0);
        tick();
        m_axi_awready = 1'b1;
        #1;
        chk("sp_awvalid4", 64'(m_axi_awvalid), 64'd1);
        chk("sp_nogrant4", 64'(s_awready), 64'd0);
        tick();
        chk("sp_awvalid_drop", 64'(m_axi_awvalid), 64'd0);
        chk("sp_next_grant", 64'(s_awready), 64'h2);
        tick();
        s_awvalid = '0; s_wvalid = '0;
        #1;
        chk("sp_awid1", 64'(m_axi_awid), 64'd1);
        chk("sp_out2", 64'(outstanding_o), 64'd2);
        tick();

        // Fill to the outstanding limit: grants 2,3,0,1,2,3
        s_awvalid = 4'hF; s_wvalid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            tick();
            tick();
        end
        #1;
        chk("lim_out8", 64'(outstanding_o), 64'd8);
        chk("lim_stall1", 64'(s_awready), 64'd0);
        tick();
        chk("lim_stall2", 64'(s_awready), 64'd0);
        chk("lim_no_awvalid", 64'(m_axi_awvalid), 64'd0);
        m_axi_bvalid = 1'b1; m_axi_bid = 4'd3; m_axi_bresp = 2'b00;
        #1;
        chk("lim_b_same_cycle", 64'(s_awready), 64'd0);
        tick();
        // Grant to requester 0 in the same cycle as an SLVERR B for requester 1
        m_axi_bid = 4'd1; m_axi_bresp = 2'b10;
        #1;
        chk("lim_out7", 64'(outstanding_o), 64'd7);
        chk("lim_bvalid3", 64'(s_bvalid), 64'h8);
        chk("lim_grant_after_b", 64'(s_awready), 64'h1);
        tick();
        m_axi_bvalid = 1'b0;
        // Hold the master off so the transfer is still in flight for the reset check
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        #1;
        chk("sim_out_unchanged", 64'(outstanding_o), 64'd7);
        chk("sim_bvalid1", 64'(s_bvalid), 64'h2);
        chk("sim_bresp", 64'(s_bresp), 64'h2);
        chk("sim_awid0", 64'(m_axi_awid), 64'd0);
        tick();
        chk("rx_awvalid_held", 64'(m_axi_awvalid), 64'd1);
        chk("rx_wvalid_held", 64'(m_axi_wvalid), 64'd1);

        // Reset during XFER
        rst_n = 1'b0;
        #1;
        chk("rx_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rx_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("rx_out", 64'(outstanding_o), 64'd0);
        chk("rx_awready", 64'(s_awready), 64'd0);
        tick();
        rst_n = 1'b1;
        s_awvalid = '0; s_wvalid = '0;
        m_axi_bvalid = 1'b1; m_axi_bid = 4'd2; m_axi_bresp = 2'b00;
        tick();
        m_axi_bvalid = 1'b0;
        #1;
        chk("rx_late_bvalid", 64'(s_bvalid), 64'h4);
        chk("rx_out_sat", 64'(outstanding_o), 64'd0);
        s_awvalid = 4'hF; s_wvalid = 4'hF;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        #1;
        chk("rx_first_grant0", 64'(s_awready), 64'h1);
        tick();
        chk("rx_awid0", 64'(m_axi_awid), 64'd0);
        chk("rx_out1", 64'(outstanding_o), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
